// File: rtl/program_feeder_if.sv
// Program load port of the instruction feeder: valid/ready word stream
// bracketed by start/done pulses.
interface program_feeder_if #(
    parameter int IW = 14
);
    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;
    logic          load_done;

    modport master (
        output load_start, load_valid, load_data, load_done,
        input  load_ready
    );

    modport slave (
        input  load_start, load_valid, load_data, load_done,
        output load_ready
    );
endinterface

// File: rtl/program_feeder.sv
// Program memory and instruction streamer for the 8-bit common-bus CPU.
// Optional FEEDER_READBACK_EN adds a registered memory readback port.
module program_feeder #(
    parameter int DEPTH = 16,
    parameter int IW    = 14
) (
    input  logic                     clock,
    input  logic                     reset_n,
    program_feeder_if.slave          ld,
    input  logic                     run,
    input  logic [7:0]               pc,
    output logic [IW-1:0]            instruction,
    output logic                     reg_val_or_pc,
    output logic [1:0]               state,
    output logic                     halted,
`ifdef FEEDER_READBACK_EN
    input  logic [$clog2(DEPTH)-1:0] rb_addr,
    output logic [IW-1:0]            rb_data,
`endif
    output logic [$clog2(DEPTH):0]   word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [IW-1:0] mem [DEPTH];
    logic [6:0]    idx_ext;
    logic          hit;
    logic          accept;
    logic          clear_count;
    logic          unused_pc_lsb;

    // pc advances by 4, so the low two bits never address a word.
    assign unused_pc_lsb = ^pc[1:0];
    assign idx_ext       = {1'b0, pc[7:2]};
    assign hit           = idx_ext < 7'(word_count);
    assign clear_count   = ld.load_start && (cur_state == S_IDLE || cur_state == S_LOAD);
    assign accept        = (cur_state == S_LOAD) && ld.load_valid && ld.load_ready && !ld.load_start;
    assign state         = cur_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (ld.load_start) begin
                    nxt_state = S_LOAD;
                end else if (run && word_count != '0) begin
                    nxt_state = S_RUN;
                end
            end
            S_LOAD: begin
                if (!ld.load_start && ld.load_done) begin
                    nxt_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (!run) begin
                    nxt_state = S_IDLE;
                end else if (!hit) begin
                    nxt_state = S_HALT;
                end
            end
            default: begin
                if (!run) begin
                    nxt_state = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ld.load_ready = (cur_state == S_LOAD) && (word_count < CW'(DEPTH));
        halted        = (cur_state == S_HALT);
        reg_val_or_pc = (cur_state == S_HALT);
    end

    // A full memory deasserts load_ready, so the pointer never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
        end else if (clear_count) begin
            word_count <= '0;
        end else if (accept) begin
            word_count <= word_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[word_count[AW-1:0]] <= ld.load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instruction <= '0;
        end else if (cur_state == S_RUN && run && hit) begin
            instruction <= mem[pc[2 +: AW]];
        end else begin
            instruction <= '0;
        end
    end

`ifdef FEEDER_READBACK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rb_data <= '0;
        end else begin
            rb_data <= mem[rb_addr];
        end
    end
`endif
endmodule

// File: tb/tb_program_feeder.sv
// Scoreboard bench for program_feeder: loads programs, streams them by pc,
// and exercises overflow, start/run priority, halt and async reset.
module tb_program_feeder;
    localparam int DEPTH = 16;
    localparam int IW    = 14;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic [7:0]    pc = 8'd0;
    logic [IW-1:0] instruction;
    logic          reg_val_or_pc;
    logic [1:0]    state;
    logic          halted;
    logic [CW-1:0] word_count;
`ifdef FEEDER_READBACK_EN
    logic [$clog2(DEPTH)-1:0] rb_addr = '0;
    logic [IW-1:0]            rb_data;
`endif

    program_feeder_if #(.IW(IW)) ld ();

    program_feeder #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ld            (ld.slave),
        .run           (run),
        .pc            (pc),
        .instruction   (instruction),
        .reg_val_or_pc (reg_val_or_pc),
        .state         (state),
        .halted        (halted),
`ifdef FEEDER_READBACK_EN
        .rb_addr       (rb_addr),
        .rb_data       (rb_data),
`endif
        .word_count    (word_count)
    );

    always #5 clock = ~clock;

    int            errors = 0;
    int            checks = 0;
    logic [IW-1:0] model_mem [DEPTH];
    int            mcount = 0;
    logic [IW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_load();
        ld.load_start = 1'b1;
        step();
        ld.load_start = 1'b0;
        mcount = 0;
    endtask

    task automatic push_word(input logic [IW-1:0] d);
        ld.load_valid = 1'b1;
        ld.load_data  = d;
        if (mcount < DEPTH) begin
            model_mem[mcount] = d;
            mcount++;
        end
        step();
        ld.load_valid = 1'b0;
    endtask

    task automatic end_load();
        ld.load_done = 1'b1;
        step();
        ld.load_done = 1'b0;
    endtask

    task automatic drive_pc(input logic [7:0] p);
        int idx;
        logic [IW-1:0] e;
        pc  = p;
        idx = int'(p) >> 2;
        e   = (idx < mcount) ? model_mem[idx] : '0;
        exp_q.push_back(e);
        step();
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check($sformatf("instr_pc%0d", p), 32'(instruction), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        ld.load_start = 1'b0;
        ld.load_valid = 1'b0;
        ld.load_data  = '0;
        ld.load_done  = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_ready", 32'(ld.load_ready), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_rvp", 32'(reg_val_or_pc), 32'd0);
        reset_n = 1'b1;
        step();

        // Three words with gaps in load_valid.
        begin_load();
        check("load_state", 32'(state), 32'd1);
        check("load_ready", 32'(ld.load_ready), 32'd1);
        push_word(14'h0011); step();
        push_word(14'h0022); step(); step();
        push_word(14'h0033);
        end_load();
        check("wc3", 32'(word_count), 32'd3);
        check("idle_after_done", 32'(state), 32'd0);

        run = 1'b1;
        step();
        check("run_state", 32'(state), 32'd2);
        drive_pc(8'd0);
        drive_pc(8'd4);
        drive_pc(8'd8);
        check("run_rvp", 32'(reg_val_or_pc), 32'd0);
        drive_pc(8'd12);
        check("halt_state", 32'(state), 32'd3);
        check("halted", 32'(halted), 32'd1);
        check("halt_rvp", 32'(reg_val_or_pc), 32'd1);
        run = 1'b0;
        step();
        check("halt_to_idle", 32'(state), 32'd0);
        check("idle_halted", 32'(halted), 32'd0);

        // Overflow: 17 words into a 16-deep memory.
        begin_load();
        for (int i = 0; i < DEPTH + 1; i++) begin
            check($sformatf("ovf_ready%0d", i), 32'(ld.load_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            push_word(IW'($urandom));
        end
        check("wc_full", 32'(word_count), 32'(DEPTH));
        end_load();
        run = 1'b1;
        step();
        drive_pc(8'd0);
        drive_pc(8'd5);
        drive_pc(8'd60);
        drive_pc(8'd64);
        check("halt_ovf", 32'(state), 32'd3);
        ld.load_start = 1'b1;
        step();
        ld.load_start = 1'b0;
        check("halt_ignores_start", 32'(state), 32'd3);
        run = 1'b0;
        step();

        // load_start beats run; run with an empty program is ignored.
        begin_load();
        for (int i = 0; i < 5; i++) push_word(IW'(i + 1));
        end_load();
        check("wc5", 32'(word_count), 32'd5);
        ld.load_start = 1'b1;
        run = 1'b1;
        step();
        ld.load_start = 1'b0;
        run = 1'b0;
        mcount = 0;
        check("start_wins", 32'(state), 32'd1);
        check("start_clears_wc", 32'(word_count), 32'd0);
        end_load();
        run = 1'b1;
        step();
        check("empty_run_ignored", 32'(state), 32'd0);
        run = 1'b0;

        // Asynchronous reset mid-load, then mid-run.
        begin_load();
        push_word(14'h0101);
        push_word(14'h0202);
        ld.load_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        ld.load_valid = 1'b0;
        mcount = 0;
        check("rst_load_state", 32'(state), 32'd0);
        check("rst_load_wc", 32'(word_count), 32'd0);
        check("rst_load_ready", 32'(ld.load_ready), 32'd0);
        reset_n = 1'b1;
        step();
        begin_load();
        push_word(14'h0A0A);
        push_word(14'h0B0B);
        end_load();
        run = 1'b1;
        step();
        drive_pc(8'd4);
        #1 reset_n = 1'b0;
        #1;
        check("rst_run_instr", 32'(instruction), 32'd0);
        check("rst_run_state", 32'(state), 32'd0);
        check("rst_run_wc", 32'(word_count), 32'd0);
        check("rst_run_halted", 32'(halted), 32'd0);
        check("rst_run_rvp", 32'(reg_val_or_pc), 32'd0);
        run = 1'b0;
        mcount = 0;
        reset_n = 1'b1;
        step();

`ifdef FEEDER_READBACK_EN
        begin_load();
        push_word(14'h0001);
        push_word(14'h0002);
        push_word(14'h1ABC);
        end_load();
        rb_addr = 2;
        step();
        check("readback", 32'(rb_data), 32'h1ABC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_feeder.md
# program_feeder

Instruction-side partner of the 8-bit common-bus CPU. It holds a small program memory, accepts a program over a valid/ready load port, and then streams 14-bit instruction words to the CPU's instruction pins, indexed by the CPU's program counter. It also drives the CPU's PC/register display select. It sits between the board-level program source and the CPU core.

## Interface
- DEPTH, 16: number of program words; power of two, at most 64.
- IW, 14: instruction width; matches the CPU's `{ui_in, uio_in[7:2]}` field.
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that opens a program load.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  the feeder accepts a word this cycle.
- load_data  in  IW  program word.
- load_done  in  1  pulse that closes the load.
- run  in  1  level; start, and remain in, execution.
- pc  in  8  CPU program counter, sampled from the CPU display with reg_val_or_pc=0.
- instruction  out  IW  word presented to the CPU instruction pins.
- reg_val_or_pc  out  1  CPU display select; 0 selects PC, 1 selects the output register.
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
- halted  out  1  high in HALT.
- word_count  out  $clog2(DEPTH)+1  number of words loaded.

## Operation
- Reset values: state IDLE, write pointer 0, word_count 0, instruction 0, load_ready 0, halted 0, reg_val_or_pc 0. Memory contents are not reset.
- IDLE
  - load_start → LOAD; the write pointer and word_count are cleared.
  - run=1 with word_count≠0 → RUN.
  - If load_start and run arrive together, LOAD wins.
  - run=1 with word_count=0 is ignored.
- LOAD
  - load_ready=1 while word_count<DEPTH.
  - Each cycle with load_valid&&load_ready writes mem[ptr]<=load_data; ptr and word_count increment.
  - At word_count=DEPTH, load_ready=0; further valid words are dropped and the pointer does not wrap.
  - load_done → IDLE. A word accepted in the same cycle as load_done is still written.
  - load_start while in LOAD restarts the load from 0.
- RUN
  - Each cycle, idx=pc[7:2] (PC advances by 4, so pc[1:0] is ignored).
  - If idx<word_count: instruction<=mem[idx].
  - Otherwise: instruction<=0, state→HALT. This covers idx≥DEPTH.
  - reg_val_or_pc=0 throughout.
  - run deasserted → IDLE with instruction<=0.
- HALT
  - halted=1, instruction=0, reg_val_or_pc=1 so the result register is displayed.
  - run deasserted → IDLE. load_start is ignored until IDLE is reached.
- Reset in any state returns immediately to the reset values. A partial load is discarded (word_count=0).

## Timing
- instruction is registered: valid exactly 1 clock after the pc sample it depends on. CPU microcode must present the PC at least 1 cycle before its IR load.
- load_ready is combinational from state and word_count; no same-cycle dependence on load_valid.
- The state output and halted change on the clock edge after the triggering input.
- The first instruction appears 1 cycle after entering RUN (first RUN cycle samples pc).

## Configuration
- FEEDER_READBACK_EN defined:
  - Adds ports rb_addr (in, $clog2(DEPTH)) and rb_data (out, IW).
  - rb_data<=mem[rb_addr] with 1-cycle latency, in any state; reset value 0.
- FEEDER_READBACK_EN not defined: the ports and read logic are absent; behaviour is otherwise identical.

## Test plan
- Load 3 words 14'h0011, 14'h0022, 14'h0033 with gaps in load_valid, then load_done → word_count=3, state IDLE.
- Run with pc=0,4,8 → instruction 0x0011, 0x0022, 0x0033, each 1 cycle after its pc. pc=12 → instruction 0, HALT, halted=1, reg_val_or_pc=1.
- Load 17 words at DEPTH=16 → load_ready drops after word 16, word_count=16, word 17 not stored. Run with pc=60 → mem[15]; pc=64 → HALT.
- load_start and run together in IDLE with word_count=5 → state LOAD, word_count=0. run with word_count=0 → stays IDLE.
- reset_n low mid-load after 2 words, then in RUN → all outputs return to reset values asynchronously; word_count=0.
- With FEEDER_READBACK_EN: after loading 0x1ABC at address 2, rb_addr=2 → rb_data=0x1ABC on the next cycle.
